// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared servo PWM constants, decoder state type and us-to-cycles helper
package servo_pkg;

  localparam int CLK_FREQ_HZ     = 25_000_000;
  localparam int SERVO_PERIOD_US = 20_000;
  localparam int SERVO_DOWN_US   = 1_000;
  localparam int SERVO_UP_US     = 1_500;

  localparam int HI_W  = 17;
  localparam int PER_W = 20;

  typedef enum logic [1:0] {
    ESPERA,
    ALTO,
    BAJO
  } dec_state_t;

  function automatic longint us_to_cycles(input longint us, input longint clk_hz);
    return (us * clk_hz) / 1_000_000;
  endfunction

endpackage

// File: rtl/pwm_input_sync.sv
// rtl/pwm_input_sync.sv - 2-FF synchroniser, optional stability filter (SERVO_PWM_GLITCH_FILTER_EN)
// and registered rise/fall strobes; o_level is aligned with the strobes.
module pwm_input_sync
`ifdef SERVO_PWM_GLITCH_FILTER_EN
  #(parameter int FILTER_LEN = 4)
`endif
  (
  input  logic clk,
  input  logic reset,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta, r_sync, r_prev, r_rise, r_fall;
  logic w_level;

  // The input chain is left unreset so a reset never fabricates an edge.
  always_ff @(posedge clk) begin
    r_meta <= i_pwm;
    r_sync <= r_meta;
  end

`ifdef SERVO_PWM_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN) + 1;
  logic [CW-1:0] r_cnt;
  logic          r_filt;

  always_ff @(posedge clk) begin
    if (r_sync == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
      r_filt <= r_sync;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync;
`endif

  always_ff @(posedge clk) begin
    r_prev <= w_level;
    if (reset) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_level & ~r_prev;
      r_fall <= ~w_level & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - servo PWM frame decoder: measures high time/period, validates, decodes up/down
// Optional glitch filter via SERVO_PWM_GLITCH_FILTER_EN.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = servo_pkg::CLK_FREQ_HZ,
  parameter int PERIOD_US     = SERVO_PERIOD_US,
  parameter int PERIOD_TOL_US = 2_000,
  parameter int MIN_PULSE_US  = 500,
  parameter int MAX_PULSE_US  = 2_500,
  parameter int THRESHOLD_US  = 1_250
`ifdef SERVO_PWM_GLITCH_FILTER_EN
  , parameter int FILTER_LEN  = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [HI_W-1:0]  ancho_pulso,
  output logic [PER_W-1:0] periodo,
  output logic             banderin_arriba,
  output logic             dato_valido,
  output logic             error_formato,
  output logic             timeout
);

  localparam logic [PER_W-1:0] PER_NOM = PER_W'(us_to_cycles(PERIOD_US, CLK_FREQ_HZ));
  localparam logic [PER_W-1:0] PER_TOL = PER_W'(us_to_cycles(PERIOD_TOL_US, CLK_FREQ_HZ));
  localparam logic [PER_W-1:0] PER_LO  = PER_NOM - PER_TOL;
  localparam logic [PER_W-1:0] PER_HI  = PER_NOM + PER_TOL;
  localparam logic [HI_W-1:0]  HI_MIN  = HI_W'(us_to_cycles(MIN_PULSE_US, CLK_FREQ_HZ));
  localparam logic [HI_W-1:0]  HI_MAX  = HI_W'(us_to_cycles(MAX_PULSE_US, CLK_FREQ_HZ));
  localparam logic [HI_W-1:0]  HI_THR  = HI_W'(us_to_cycles(THRESHOLD_US, CLK_FREQ_HZ));

  logic w_level, w_rise, w_fall;

  pwm_input_sync
`ifdef SERVO_PWM_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
    u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_pwm   (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  dec_state_t       r_state, w_state_nxt;
  logic [HI_W-1:0]  r_hi, w_hi_nxt, w_hi_inc;
  logic [PER_W-1:0] r_per, w_per_nxt, w_per_inc;
  logic [HI_W-1:0]  r_ancho;
  logic [PER_W-1:0] r_periodo;
  logic             r_arriba, r_dv, r_err, r_tmo;
  logic             w_dv_nxt, w_err_nxt, w_tmo_nxt, w_load, w_legal;

  assign w_hi_inc  = (r_hi == '1) ? r_hi : r_hi + HI_W'(1);
  assign w_per_inc = (r_per == '1) ? r_per : r_per + PER_W'(1);
  assign w_legal   = (r_hi >= HI_MIN) && (r_hi <= HI_MAX) && (r_per >= PER_LO) && (r_per <= PER_HI);

  // Counters restart at 1 on a rise: the rise cycle itself belongs to the new frame.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_nxt    = r_hi;
    w_per_nxt   = r_per;
    w_dv_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_tmo_nxt   = r_tmo;
    w_load      = 1'b0;
    unique case (r_state)
      ESPERA: begin
        if (w_rise) begin
          w_state_nxt = ALTO;
          w_hi_nxt    = HI_W'(1);
          w_per_nxt   = PER_W'(1);
          w_tmo_nxt   = 1'b0;
        end
      end
      ALTO, BAJO: begin
        if (r_state == BAJO && w_rise) begin
          w_dv_nxt    = w_legal;
          w_err_nxt   = ~w_legal;
          w_load      = w_legal;
          w_state_nxt = ALTO;
          w_hi_nxt    = HI_W'(1);
          w_per_nxt   = PER_W'(1);
        end else if (r_per >= PER_HI) begin
          w_tmo_nxt   = 1'b1;
          w_state_nxt = ESPERA;
        end else begin
          w_per_nxt = w_per_inc;
          if (r_state == ALTO) begin
            if (w_level) w_hi_nxt = w_hi_inc;
            if (w_fall)  w_state_nxt = BAJO;
          end
        end
      end
      default: w_state_nxt = ESPERA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ESPERA;
      r_hi      <= '0;
      r_per     <= '0;
      r_ancho   <= '0;
      r_periodo <= '0;
      r_arriba  <= 1'b0;
      r_dv      <= 1'b0;
      r_err     <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hi    <= w_hi_nxt;
      r_per   <= w_per_nxt;
      r_dv    <= w_dv_nxt;
      r_err   <= w_err_nxt;
      r_tmo   <= w_tmo_nxt;
      if (w_load) begin
        r_ancho   <= r_hi;
        r_periodo <= r_per;
        r_arriba  <= (r_hi >= HI_THR);
      end
    end
  end

  assign ancho_pulso     = r_ancho;
  assign periodo         = r_periodo;
  assign banderin_arriba = r_arriba;
  assign dato_valido     = r_dv;
  assign error_formato   = r_err;
  assign timeout         = r_tmo;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - self-checking bench for servo_pwm_decoder (scaled clock: 1 us = 0.1 cycle)
module tb_servo_pwm_decoder;

  // At 100 kHz: period 2000, tol 200, min 50, max 250, threshold 125, timeout 2200.
  localparam int TB_CLK_HZ = 100_000;
  localparam int TMO       = 2200;
`ifdef SERVO_PWM_GLITCH_FILTER_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_in;
  logic [16:0] ancho_pulso;
  logic [19:0] periodo;
  logic        banderin_arriba, dato_valido, error_formato, timeout;

  servo_pwm_decoder #(.CLK_FREQ_HZ(TB_CLK_HZ)) dut (
    .clk             (clk),
    .reset           (reset),
    .pwm_in          (pwm_in),
    .ancho_pulso     (ancho_pulso),
    .periodo         (periodo),
    .banderin_arriba (banderin_arriba),
    .dato_valido     (dato_valido),
    .error_formato   (error_formato),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int hi;
    int per;
    bit ok;
    int ancho;
    int periodo;
    bit arriba;
  } vec_t;

  typedef struct {
    bit ok;
    int ancho;
    int periodo;
    bit arriba;
    int cyc;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  exp_t e;
  int   n_total = 0;
  int   n_pass  = 0;
  int   t0, t1, t2, t3, t4;

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic wait_until(input int target);
    if (cyc < target) begin
      repeat (target - cyc) @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input bit ok, input int a, input int p, input bit arr);
    sb.push_back('{ok, a, p, arr, cyc + LAT});
  endtask

  task automatic frame(input int hi, input int per);
    int c;
    c = cyc;
    pwm_in = 1'b1;
    wait_until(c + hi);
    pwm_in = 1'b0;
    wait_until(c + per);
  endtask

  // Scoreboard: each strobe must match the oldest expectation on its exact cycle.
  always @(negedge clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("strobe_missing", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (dato_valido || error_formato) begin
        chk("strobe_exclusive", int'(dato_valido && error_formato), 0);
        if (sb.size() == 0) begin
          chk("unexpected_strobe", cyc, -1);
        end else begin
          e = sb.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe_valid", int'(dato_valido), int'(e.ok));
          chk("ancho_pulso", int'(ancho_pulso), e.ancho);
          chk("periodo", int'(periodo), e.periodo);
          chk("banderin_arriba", int'(banderin_arriba), int'(e.arriba));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ancho"}, int'(ancho_pulso), 0);
    chk({tag, "_periodo"}, int'(periodo), 0);
    chk({tag, "_arriba"}, int'(banderin_arriba), 0);
    chk({tag, "_valido"}, int'(dato_valido), 0);
    chk({tag, "_error"}, int'(error_formato), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    vecs[0]  = '{100, 2000, 1'b1, 100, 2000, 1'b0};
    vecs[1]  = '{100, 2000, 1'b1, 100, 2000, 1'b0};
    vecs[2]  = '{150, 2000, 1'b1, 150, 2000, 1'b1};
    vecs[3]  = '{150, 1500, 1'b0, 150, 2000, 1'b1};
    vecs[4]  = '{125, 2000, 1'b1, 125, 2000, 1'b1};
    vecs[5]  = '{124, 1800, 1'b1, 124, 1800, 1'b0};
    vecs[6]  = '{ 50, 2200, 1'b1,  50, 2200, 1'b0};
    vecs[7]  = '{250, 2000, 1'b1, 250, 2000, 1'b1};
    vecs[8]  = '{ 49, 2000, 1'b0, 250, 2000, 1'b1};
    vecs[9]  = '{251, 2000, 1'b0, 250, 2000, 1'b1};
    vecs[10] = '{100, 1799, 1'b0, 250, 2000, 1'b1};
    vecs[11] = '{100, 2000, 1'b1, 100, 2000, 1'b0};

    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_until(cyc + 5);

    // Frame i is closed (and its expectation pushed) by the rise that opens frame i+1.
    for (int i = 0; i < 12; i++) begin
      if (i > 0) push_exp(vecs[i-1].ok, vecs[i-1].ancho, vecs[i-1].periodo, vecs[i-1].arriba);
      frame(vecs[i].hi, vecs[i].per);
    end
    push_exp(vecs[11].ok, vecs[11].ancho, vecs[11].periodo, vecs[11].arriba);

    t0 = cyc;
    pwm_in = 1'b1;
    wait_until(t0 + 100);
    pwm_in = 1'b0;
    wait_until(t0 + LAT + TMO - 1);
    @(negedge clk);
    chk("timeout_before_limit", int'(timeout), 0);
    @(negedge clk);
    chk("timeout_at_limit", int'(timeout), 1);
    chk("timeout_held_ancho", int'(ancho_pulso), 100);
    chk("timeout_held_periodo", int'(periodo), 2000);

    @(posedge clk);
    #1;
    t1 = cyc;
    pwm_in = 1'b1;
    wait_until(t1 + LAT - 1);
    @(negedge clk);
    chk("timeout_kept_until_edge", int'(timeout), 1);
    @(negedge clk);
    chk("timeout_cleared_by_edge", int'(timeout), 0);
    @(posedge clk);
    #1;
    wait_until(t1 + 150);
    pwm_in = 1'b0;
    wait_until(t1 + 2000);
    push_exp(1'b1, 150, 2000, 1'b1);

    t2 = cyc;
    pwm_in = 1'b1;
    wait_until(t2 + 50);
    reset = 1'b1;
    wait_until(t2 + 51);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    wait_until(t2 + 150);
    pwm_in = 1'b0;
    wait_until(t2 + 2000);

    t3 = cyc;
    frame(100, 2000);
    push_exp(1'b1, 100, 2000, 1'b0);

    t4 = cyc;
    pwm_in = 1'b1;
    wait_until(t4 + 100);
    pwm_in = 1'b0;
    wait_until(t4 + 1000);
`ifndef SERVO_PWM_GLITCH_FILTER_EN
    push_exp(1'b0, 100, 2000, 1'b0);
`endif
    pwm_in = 1'b1;
    wait_until(t4 + 1003);
    pwm_in = 1'b0;
    wait_until(t4 + 2000);
`ifdef SERVO_PWM_GLITCH_FILTER_EN
    push_exp(1'b1, 100, 2000, 1'b0);
`else
    push_exp(1'b0, 100, 2000, 1'b0);
`endif
    pwm_in = 1'b1;
    wait_until(cyc + LAT + 10);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
